// File: rtl/capture_reg_arbiter_if.sv
// capture_reg_arbiter_if: requester-side bundle for the shared capture register arbiter.
// Optional macro CAPTURE_REG_ARBITER_LOCK_EN adds the per-requester LOCK input.
interface capture_reg_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            REQ;
  logic [NUM_REQ*DATA_WIDTH-1:0] DIN;
`ifdef CAPTURE_REG_ARBITER_LOCK_EN
  logic [NUM_REQ-1:0]            LOCK;
`endif
  logic [NUM_REQ-1:0]            GNT;
  logic [SRC_W-1:0]              SRC;
  logic                          E;
  logic [DATA_WIDTH-1:0]         D;
  logic [DATA_WIDTH-1:0]         Q;
  logic                          BUSY;

`ifdef CAPTURE_REG_ARBITER_LOCK_EN
  modport master (output REQ, DIN, LOCK, input GNT, SRC, E, D, Q, BUSY);
  modport slave  (input REQ, DIN, LOCK, output GNT, SRC, E, D, Q, BUSY);
`else
  modport master (output REQ, DIN, input GNT, SRC, E, D, Q, BUSY);
  modport slave  (input REQ, DIN, output GNT, SRC, E, D, Q, BUSY);
`endif
endinterface

// File: rtl/capture_reg_arbiter.sv
// capture_reg_arbiter: round-robin arbiter sharing one enable-gated capture register
// between NUM_REQ requesters, with a HOLD_CYCLES quiet window after each capture.
// Optional macro CAPTURE_REG_ARBITER_LOCK_EN lets the last winner keep the register
// while it holds LOCK and REQ.
module capture_reg_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = 2
) (
  input logic                  C,
  input logic                  R,
  capture_reg_arbiter_if.slave bus
);
  localparam int                  SRC_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [SRC_W:0]      NUM_REQ_EXT = (SRC_W + 1)'(NUM_REQ);
  localparam logic [SRC_W-1:0]    LAST_IDX    = SRC_W'(NUM_REQ - 1);
  localparam logic [7:0]          HOLD_INIT   = 8'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);
  localparam logic [NUM_REQ-1:0]  ONE_HOT0    = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} arbState_t;

  arbState_t             r_state;
  logic [NUM_REQ-1:0]    r_gnt;
  logic                  r_e;
  logic [DATA_WIDTH-1:0] r_d;
  logic [DATA_WIDTH-1:0] r_q;
  logic [SRC_W-1:0]      r_src;
  logic [SRC_W-1:0]      r_ptr;
  logic [7:0]            r_cnt;
  logic                  r_busy;

  arbState_t             w_stateNext;
  logic [NUM_REQ-1:0]    w_gntNext;
  logic                  w_eNext;
  logic [DATA_WIDTH-1:0] w_dNext;
  logic [SRC_W-1:0]      w_srcNext;
  logic [SRC_W-1:0]      w_ptrNext;
  logic [7:0]            w_cntNext;

  logic                  w_found;
  logic [SRC_W-1:0]      w_winner;
  logic [SRC_W:0]        w_scanSum;
  logic [SRC_W-1:0]      w_scanIdx;
  logic                  w_grantValid;
  logic [SRC_W-1:0]      w_grantIdx;
  logic                  w_advancePtr;
  logic [SRC_W-1:0]      w_ptrAfter;

`ifdef CAPTURE_REG_ARBITER_LOCK_EN
  logic                  r_srcValid;
  logic                  w_srcValidNext;
`endif

  // Scan upward from the rr pointer with wrap-around; first requester found wins
  always_comb begin
    w_found   = 1'b0;
    w_winner  = '0;
    w_scanSum = '0;
    w_scanIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scanSum = {1'b0, r_ptr} + (SRC_W + 1)'(i);
      if (w_scanSum >= NUM_REQ_EXT) w_scanSum = w_scanSum - NUM_REQ_EXT;
      w_scanIdx = w_scanSum[SRC_W-1:0];
      if (!w_found && bus.REQ[w_scanIdx]) begin
        w_found  = 1'b1;
        w_winner = w_scanIdx;
      end
    end
  end

  // Pick the grant target: a locked previous winner overrides the scan and freezes the pointer
  always_comb begin
    w_grantValid = w_found;
    w_grantIdx   = w_winner;
    w_advancePtr = w_found;
`ifdef CAPTURE_REG_ARBITER_LOCK_EN
    if (r_srcValid && bus.LOCK[r_src] && bus.REQ[r_src]) begin
      w_grantValid = 1'b1;
      w_grantIdx   = r_src;
      w_advancePtr = 1'b0;
    end
`endif
    w_ptrAfter = (w_grantIdx == LAST_IDX) ? '0 : w_grantIdx + 1'b1;
  end

  // Next-state and next-output logic; grant and enable are single-cycle pulses
  always_comb begin
    w_stateNext = r_state;
    w_gntNext   = '0;
    w_eNext     = 1'b0;
    w_dNext     = r_d;
    w_srcNext   = r_src;
    w_ptrNext   = r_ptr;
    w_cntNext   = r_cnt;
`ifdef CAPTURE_REG_ARBITER_LOCK_EN
    w_srcValidNext = r_srcValid;
`endif
    case (r_state)
      IDLE: begin
        if (w_grantValid) begin
          w_stateNext = CAPTURE;
          w_gntNext   = ONE_HOT0 << w_grantIdx;
          w_eNext     = 1'b1;
          w_dNext     = bus.DIN[w_grantIdx*DATA_WIDTH +: DATA_WIDTH];
          w_srcNext   = w_grantIdx;
          if (w_advancePtr) w_ptrNext = w_ptrAfter;
`ifdef CAPTURE_REG_ARBITER_LOCK_EN
          w_srcValidNext = 1'b1;
`endif
        end
      end
      CAPTURE: begin
        if (HOLD_CYCLES == 0) begin
          w_stateNext = IDLE;
        end else begin
          w_stateNext = HOLD;
          w_cntNext   = HOLD_INIT;
        end
      end
      HOLD: begin
        if (r_cnt == 8'd0) w_stateNext = IDLE;
        else               w_cntNext   = r_cnt - 8'd1;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge C) begin
    if (R) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_e     <= 1'b0;
      r_d     <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
`ifdef CAPTURE_REG_ARBITER_LOCK_EN
      r_srcValid <= 1'b0;
`endif
    end else begin
      r_state <= w_stateNext;
      r_gnt   <= w_gntNext;
      r_e     <= w_eNext;
      r_d     <= w_dNext;
      r_src   <= w_srcNext;
      r_ptr   <= w_ptrNext;
      r_cnt   <= w_cntNext;
      r_busy  <= (w_stateNext != IDLE);
`ifdef CAPTURE_REG_ARBITER_LOCK_EN
      r_srcValid <= w_srcValidNext;
`endif
    end
  end

  // Shared capture register: loads D only while E is high; reset discards any in-flight capture
  always_ff @(posedge C) begin
    if (R)        r_q <= '0;
    else if (r_e) r_q <= r_d;
  end

  assign bus.GNT  = r_gnt;
  assign bus.SRC  = r_src;
  assign bus.E    = r_e;
  assign bus.D    = r_d;
  assign bus.Q    = r_q;
  assign bus.BUSY = r_busy;
endmodule

// File: tb/tb_capture_reg_arbiter.sv
// tb_capture_reg_arbiter: table-driven check of capture_reg_arbiter (HOLD_CYCLES=2)
// plus hand sequences for mid-capture reset and a HOLD_CYCLES=0 instance.
// Honours CAPTURE_REG_ARBITER_LOCK_EN when defined.
module tb_capture_reg_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam logic [31:0] DIN_RR = 32'h13121110;
  localparam logic [31:0] DIN_A5 = 32'h00A50000;

  logic C;
  logic R;
  int   nChecks;
  int   nFails;

  capture_reg_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW)) bus  ();
  capture_reg_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW)) bus0 ();

  capture_reg_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .HOLD_CYCLES(2)) dut (
    .C(C), .R(R), .bus(bus)
  );
  capture_reg_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .HOLD_CYCLES(0)) dut0 (
    .C(C), .R(R), .bus(bus0)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic        e;
    logic [7:0]  q;
    logic        busy;
    logic [1:0]  src;
  } vec_t;

  vec_t vecs[$];

  // Free-running clock
  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  // Hard time limit so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic addVec(input logic rst, input logic [3:0] req, input logic [31:0] din,
                        input logic [3:0] gnt, input logic e, input logic [7:0] q,
                        input logic busy, input logic [1:0] src);
    vec_t v;
    v.rst = rst; v.req = req; v.din = din; v.gnt = gnt;
    v.e = e; v.q = q; v.busy = busy; v.src = src;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] req, input logic [31:0] din);
    R       = rst;
    bus.REQ = req;
    bus.DIN = din;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Main stimulus: table, then hand sequences
  initial begin
    logic [7:0] prevQ;
    int         expSeq [4];
    nChecks  = 0;
    nFails   = 0;
    R        = 1'b1;
    bus.REQ  = '0;
    bus.DIN  = '0;
    bus0.REQ = '0;
    bus0.DIN = '0;
`ifdef CAPTURE_REG_ARBITER_LOCK_EN
    bus.LOCK  = '0;
    bus0.LOCK = '0;
`endif

    // Reset held 3 cycles with all requests up
    for (int i = 0; i < 3; i++) addVec(1, 4'b1111, DIN_RR, 4'b0000, 0, 8'h00, 0, 2'd0);
    addVec(0, 4'b0000, DIN_A5, 4'b0000, 0, 8'h00, 0, 2'd0);
    // Single request from 2
    addVec(0, 4'b0100, DIN_A5, 4'b0100, 1, 8'h00, 1, 2'd2);
    addVec(0, 4'b0000, DIN_A5, 4'b0000, 0, 8'hA5, 1, 2'd2);
    addVec(0, 4'b0000, DIN_A5, 4'b0000, 0, 8'hA5, 1, 2'd2);
    addVec(0, 4'b0000, DIN_A5, 4'b0000, 0, 8'hA5, 0, 2'd2);
    // Reset to clear pointer and Q, then continuous requests: order 0,1,2,3,0
    addVec(1, 4'b0000, DIN_RR, 4'b0000, 0, 8'h00, 0, 2'd0);
    prevQ = 8'h00;
    for (int g = 0; g < 5; g++) begin
      int w;
      w = g % 4;
      addVec(0, 4'b1111, DIN_RR, 4'b0001 << w, 1, prevQ, 1, 2'(w));
      addVec(0, 4'b1111, DIN_RR, 4'b0000, 0, 8'(8'h10 + w), 1, 2'(w));
      addVec(0, 4'b1111, DIN_RR, 4'b0000, 0, 8'(8'h10 + w), 1, 2'(w));
      addVec(0, 4'b1111, DIN_RR, 4'b0000, 0, 8'(8'h10 + w), 0, 2'(w));
      prevQ = 8'(8'h10 + w);
    end
    // Grant to 3, then 0110 wraps to 1 and then 2
    addVec(0, 4'b1000, DIN_RR, 4'b1000, 1, 8'h10, 1, 2'd3);
    addVec(0, 4'b0110, DIN_RR, 4'b0000, 0, 8'h13, 1, 2'd3);
    addVec(0, 4'b0110, DIN_RR, 4'b0000, 0, 8'h13, 1, 2'd3);
    addVec(0, 4'b0110, DIN_RR, 4'b0000, 0, 8'h13, 0, 2'd3);
    addVec(0, 4'b0110, DIN_RR, 4'b0010, 1, 8'h13, 1, 2'd1);
    addVec(0, 4'b0110, DIN_RR, 4'b0000, 0, 8'h11, 1, 2'd1);
    addVec(0, 4'b0110, DIN_RR, 4'b0000, 0, 8'h11, 1, 2'd1);
    addVec(0, 4'b0110, DIN_RR, 4'b0000, 0, 8'h11, 0, 2'd1);
    addVec(0, 4'b0110, DIN_RR, 4'b0100, 1, 8'h11, 1, 2'd2);
    addVec(0, 4'b0000, DIN_RR, 4'b0000, 0, 8'h12, 1, 2'd2);
    addVec(0, 4'b0000, DIN_RR, 4'b0000, 0, 8'h12, 1, 2'd2);
    addVec(0, 4'b0000, DIN_RR, 4'b0000, 0, 8'h12, 0, 2'd2);
    // Request raised only during HOLD is ignored and not remembered
    addVec(0, 4'b0001, DIN_RR, 4'b0001, 1, 8'h12, 1, 2'd0);
    addVec(0, 4'b0000, DIN_RR, 4'b0000, 0, 8'h10, 1, 2'd0);
    addVec(0, 4'b1000, DIN_RR, 4'b0000, 0, 8'h10, 1, 2'd0);
    addVec(0, 4'b0000, DIN_RR, 4'b0000, 0, 8'h10, 0, 2'd0);
    addVec(0, 4'b0000, DIN_RR, 4'b0000, 0, 8'h10, 0, 2'd0);

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].rst, vecs[n].req, vecs[n].din);
      @(negedge C);
      checkOutput($sformatf("vec%0d GNT", n),  32'(bus.GNT),  32'(vecs[n].gnt));
      checkOutput($sformatf("vec%0d E", n),    32'(bus.E),    32'(vecs[n].e));
      checkOutput($sformatf("vec%0d Q", n),    32'(bus.Q),    32'(vecs[n].q));
      checkOutput($sformatf("vec%0d BUSY", n), 32'(bus.BUSY), 32'(vecs[n].busy));
      checkOutput($sformatf("vec%0d SRC", n),  32'(bus.SRC),  32'(vecs[n].src));
    end

    // Reset asserted in the CAPTURE cycle discards the capture
    applyStimulus(1, 4'b0000, 32'h0);
    @(negedge C);
    checkOutput("midrst pre Q", 32'(bus.Q), 32'h00);
    applyStimulus(0, 4'b0001, 32'h000000FF);
    @(negedge C);
    checkOutput("midrst grant GNT", 32'(bus.GNT), 32'h1);
    checkOutput("midrst grant D", 32'(bus.D), 32'hFF);
    applyStimulus(1, 4'b0001, 32'h000000FF);
    @(negedge C);
    checkOutput("midrst Q", 32'(bus.Q), 32'h00);
    checkOutput("midrst BUSY", 32'(bus.BUSY), 32'h0);
    checkOutput("midrst E", 32'(bus.E), 32'h0);
    checkOutput("midrst D", 32'(bus.D), 32'h00);
    applyStimulus(0, 4'b0001, 32'h0000005A);
    @(negedge C);
    checkOutput("midrst regrant GNT", 32'(bus.GNT), 32'h1);
    checkOutput("midrst regrant SRC", 32'(bus.SRC), 32'h0);
    applyStimulus(0, 4'b0000, 32'h0000005A);
    @(negedge C);
    checkOutput("midrst regrant Q", 32'(bus.Q), 32'h5A);

    // HOLD_CYCLES=0 instance: grants every 2 cycles
    applyStimulus(1, 4'b0000, 32'h0);
    @(negedge C);
`ifdef CAPTURE_REG_ARBITER_LOCK_EN
    expSeq = '{1, 1, 1, 2};
    bus0.LOCK = 4'b0010;
`else
    expSeq = '{1, 2, 1, 2};
`endif
    R        = 1'b0;
    bus0.REQ = 4'b0110;
    bus0.DIN = DIN_RR;
    for (int c = 0; c < 8; c++) begin
`ifdef CAPTURE_REG_ARBITER_LOCK_EN
      if (c == 5) bus0.LOCK = 4'b0000;
`endif
      @(negedge C);
      if (c % 2 == 0) begin
        checkOutput($sformatf("hold0 c%0d GNT", c), 32'(bus0.GNT), 32'(4'b0001 << expSeq[c/2]));
        checkOutput($sformatf("hold0 c%0d BUSY", c), 32'(bus0.BUSY), 32'h1);
      end else begin
        checkOutput($sformatf("hold0 c%0d GNT", c), 32'(bus0.GNT), 32'h0);
        checkOutput($sformatf("hold0 c%0d Q", c), 32'(bus0.Q), 32'(8'h10 + expSeq[c/2]));
        checkOutput($sformatf("hold0 c%0d BUSY", c), 32'(bus0.BUSY), 32'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
